unidade_controle_jogo: RTL and testbench

- Moore FSM that sequences the memory-game datapath. That datapath contains:
  - an address counter (E)
  - a round-limit counter (L)
  - a sync ROM
  - a play register (R)
  - comparators
  - an edge-detected play pulse
  - a timeout counter (T)
- Each round N (N = 1..16), the player repeats the first N stored values.
- The game ends on a full 16-value round (win), a mismatch (error) or a play timeout.

---
 rtl/unidade_controle_jogo.sv | 161 ++++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogo.sv
// Memory-game control unit: Moore FSM sequencing address/limit counters, play register and timeout.
// Latency: play pulse -> verdict in 2 clocks (registra, comparacao); outputs follow state with no input paths.
// Backpressure: none; waits in espera_jogada for a play pulse (bounded by timeout when TIMEOUT_EN=1).
module unidade_controle_jogo #(
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       botoesIgualMemoria,
  input  logic       endecoIgualLimite,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       contaT,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  // State codes double as the debug display value, so they are fixed explicitly.
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hC,
    FIM_ERROU      = 4'hE
  } estado_t;

  // Control/status bundle driven towards the datapath and the display.
  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_l;
    logic conta_l;
    logic zera_r;
    logic registra_r;
    logic conta_t;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } ctrl_t;

  estado_t estado_q, estado_d;
  ctrl_t   ctrl_q, ctrl_d;
  logic    timeout_ativo;

  // Timeout only counts as an end condition when the feature is enabled.
  assign timeout_ativo = TIMEOUT_EN && timeout;

  // Moore decode of a state into its control word; unlisted states drive nothing.
  function automatic ctrl_t decodifica(input estado_t e);
    ctrl_t c;
    c = '0;
    case (e)
      PREPARACAO: begin
        c.zera_e = 1'b1;
        c.zera_l = 1'b1;
        c.zera_r = 1'b1;
      end
      INICIO_RODADA: begin
        c.zera_e = 1'b1;
        c.zera_r = 1'b1;
      end
      ESPERA_JOGADA:  c.conta_t    = 1'b1;
      REGISTRA:       c.registra_r = 1'b1;
      PROXIMA_JOGADA: c.conta_e    = 1'b1;
      PROXIMA_RODADA: c.conta_l    = 1'b1;
      FIM_ACERTOU: begin
        c.pronto  = 1'b1;
        c.acertou = 1'b1;
      end
      FIM_ERROU: begin
        c.pronto = 1'b1;
        c.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        c.pronto  = 1'b1;
        c.timeout = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic for the game sequence.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO:    estado_d = INICIO_RODADA;
      INICIO_RODADA: estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A play arriving together with timeout still counts.
        if (jogada_feita)       estado_d = REGISTRA;
        else if (timeout_ativo) estado_d = FIM_TIMEOUT;
      end
      REGISTRA:      estado_d = COMPARACAO;
      COMPARACAO: begin
        // On the last round the limit counter is never incremented, so it cannot wrap.
        if (!botoesIgualMemoria)     estado_d = FIM_ERROU;
        else if (!endecoIgualLimite) estado_d = PROXIMA_JOGADA;
        else if (fimL)               estado_d = FIM_ACERTOU;
        else                         estado_d = PROXIMA_RODADA;
      end
      PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
      PROXIMA_RODADA: estado_d = INICIO_RODADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      default: estado_d = INICIAL;
    endcase
  end

  // Control word for the state being entered, so registered outputs line up with the state register.
  always_comb begin
    ctrl_d = decodifica(estado_d);
  end

  // State and output registers; reset clears both without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      ctrl_q   <= '0;
    end else begin
      estado_q <= estado_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign zeraE      = ctrl_q.zera_e;
  assign contaE     = ctrl_q.conta_e;
  assign zeraL      = ctrl_q.zera_l;
  assign contaL     = ctrl_q.conta_l;
  assign zeraR      = ctrl_q.zera_r;
  assign registraR  = ctrl_q.registra_r;
  assign contaT     = ctrl_q.conta_t;
  assign pronto     = ctrl_q.pronto;
  assign acertou    = ctrl_q.acertou;
  assign errou      = ctrl_q.errou;
  assign db_timeout = ctrl_q.timeout;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
module tb_unidade_controle_jogo;

  logic clock = 1'b0;
  logic reset;
  logic iniciar, jogada_feita, botoes_igual, endeco_igual, fim_l, timeout_in;

  logic zeraE_a, contaE_a, zeraL_a, contaL_a, zeraR_a, registraR_a, contaT_a;
  logic pronto_a, acertou_a, errou_a, db_timeout_a;
  logic [3:0] db_estado_a;
  logic zeraE_b, contaE_b, zeraL_b, contaL_b, zeraR_b, registraR_b, contaT_b;
  logic pronto_b, acertou_b, errou_b, db_timeout_b;
  logic [3:0] db_estado_b;

  int checks = 0;
  int errors = 0;
  int st_a, st_b;

  always #5 clock = ~clock;

  unidade_controle_jogo #(.TIMEOUT_EN(1'b1)) dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .botoesIgualMemoria(botoes_igual), .endecoIgualLimite(endeco_igual), .fimL(fim_l),
    .timeout(timeout_in), .zeraE(zeraE_a), .contaE(contaE_a), .zeraL(zeraL_a),
    .contaL(contaL_a), .zeraR(zeraR_a), .registraR(registraR_a), .contaT(contaT_a),
    .pronto(pronto_a), .acertou(acertou_a), .errou(errou_a), .db_timeout(db_timeout_a),
    .db_estado(db_estado_a));

  unidade_controle_jogo #(.TIMEOUT_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .botoesIgualMemoria(botoes_igual), .endecoIgualLimite(endeco_igual), .fimL(fim_l),
    .timeout(timeout_in), .zeraE(zeraE_b), .contaE(contaE_b), .zeraL(zeraL_b),
    .contaL(contaL_b), .zeraR(zeraR_b), .registraR(registraR_b), .contaT(contaT_b),
    .pronto(pronto_b), .acertou(acertou_b), .errou(errou_b), .db_timeout(db_timeout_b),
    .db_estado(db_estado_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected control word per game phase, from the phase/output table:
  // {zeraE,contaE,zeraL,contaL,zeraR,registraR,contaT,pronto,acertou,errou,db_timeout}
  function automatic logic [10:0] expected_outs(input int st);
    case (st)
      1:  return 11'b101_0100_0000;
      2:  return 11'b100_0100_0000;
      3:  return 11'b000_0001_0000;
      4:  return 11'b000_0010_0000;
      6:  return 11'b010_0000_0000;
      7:  return 11'b000_1000_0000;
      10: return 11'b000_0000_1100;
      14: return 11'b000_0000_1010;
      12: return 11'b000_0000_1001;
      default: return 11'b0;
    endcase
  endfunction

  // Game rules: what phase follows, given the phase and this cycle's inputs.
  function automatic int next_phase(input int st, input bit ten, input bit ini, input bit jf,
                                    input bit bim, input bit eil, input bit fl, input bit to);
    if (st == 10 || st == 12 || st == 14 || st == 0) return ini ? 1 : st;
    if (st == 1) return 2;
    if (st == 2 || st == 6) return 3;
    if (st == 3) return jf ? 4 : ((ten && to) ? 12 : 3);
    if (st == 4) return 5;
    if (st == 7) return 2;
    if (st == 5) begin
      if (!bim) return 14;
      if (!eil) return 6;
      return fl ? 10 : 7;
    end
    return 0;
  endfunction

  task automatic check_both(input string tag);
    check({tag, " estado_a"}, {28'd0, db_estado_a}, st_a);
    check({tag, " saidas_a"}, {21'd0, zeraE_a, contaE_a, zeraL_a, contaL_a, zeraR_a, registraR_a,
          contaT_a, pronto_a, acertou_a, errou_a, db_timeout_a}, {21'd0, expected_outs(st_a)});
    check({tag, " estado_b"}, {28'd0, db_estado_b}, st_b);
    check({tag, " saidas_b"}, {21'd0, zeraE_b, contaE_b, zeraL_b, contaL_b, zeraR_b, registraR_b,
          contaT_b, pronto_b, acertou_b, errou_b, db_timeout_b}, {21'd0, expected_outs(st_b)});
  endtask

  // Called at a negedge: drive inputs, advance one clock, compare at the next negedge.
  task automatic step(input string tag, input bit ini, input bit jf, input bit bim,
                      input bit eil, input bit fl, input bit to);
    iniciar = ini; jogada_feita = jf; botoes_igual = bim;
    endeco_igual = eil; fim_l = fl; timeout_in = to;
    @(posedge clock);
    st_a = next_phase(st_a, 1'b1, ini, jf, bim, eil, fl, to);
    st_b = next_phase(st_b, 1'b0, ini, jf, bim, eil, fl, to);
    @(negedge clock);
    check_both(tag);
  endtask

  // Called at a negedge: pulse reset low mid-cycle and check the immediate clear.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    st_a = 0; st_b = 0;
    check({tag, " estado_async"}, {28'd0, db_estado_a}, 32'd0);
    check({tag, " contaT_async"}, {31'd0, contaT_a}, 32'd0);
    check_both(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    iniciar = 0; jogada_feita = 0; botoes_igual = 0; endeco_igual = 0; fim_l = 0; timeout_in = 0;
    st_a = 0; st_b = 0;
    #12;
    check_both("reset");
    @(negedge clock);
    reset = 1'b1;

    step("start1", 1, 0, 0, 0, 0, 0);
    step("start2", 0, 0, 0, 0, 0, 0);
    step("start3", 0, 0, 0, 0, 0, 0);
    check("espera_inicial", {28'd0, db_estado_a}, 32'h3);

    // Round 1 complete, not last round.
    step("r1_jogada", 0, 1, 0, 0, 0, 0);
    step("r1_registra", 0, 0, 0, 0, 0, 0);
    step("r1_comparacao", 0, 0, 1, 1, 0, 0);
    check("contaL_r1", {31'd0, contaL_a}, 32'd1);
    step("r1_nova", 0, 0, 0, 0, 0, 0);
    check("zeraE_r1", {31'd0, zeraE_a}, 32'd1);
    step("r1_espera", 1, 0, 0, 0, 0, 0);

    // Mid-round correct play.
    step("mid_jogada", 0, 1, 0, 0, 0, 0);
    step("mid_registra", 0, 0, 0, 0, 0, 0);
    step("mid_comparacao", 0, 0, 1, 0, 0, 0);
    check("contaE_mid", {31'd0, contaE_a}, 32'd1);
    step("mid_espera", 0, 0, 0, 0, 0, 0);

    // Play and timeout together, then a mismatch held for 10 clocks.
    step("jogada_e_timeout", 0, 1, 0, 0, 0, 1);
    check("play_wins", {28'd0, db_estado_a}, 32'h4);
    step("err_registra", 0, 0, 0, 0, 0, 0);
    step("err_comparacao", 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) step("err_hold", 0, 0, 0, 0, 0, 0);
    check("errou_hold", {28'd0, db_estado_a, errou_a, pronto_a}, 32'h3B);
    step("err_restart", 1, 0, 0, 0, 0, 0);
    step("re2", 0, 0, 0, 0, 0, 0);
    step("re3", 0, 0, 0, 0, 0, 0);

    // Timeout: ends the game only when enabled.
    step("timeout", 0, 0, 0, 0, 0, 1);
    check("timeout_a", {28'd0, db_estado_a, db_timeout_a}, 32'h19);
    check("timeout_b", {28'd0, db_estado_b}, 32'h3);
    step("to_restart", 1, 0, 0, 0, 0, 1);
    step("to2", 0, 0, 0, 0, 0, 0);
    step("to3", 0, 0, 0, 0, 0, 0);

    // Reset in the middle of espera_jogada, then restart.
    async_reset("reset_mid");
    step("pos_reset1", 1, 0, 0, 0, 0, 0);
    step("pos_reset2", 0, 0, 0, 0, 0, 0);
    step("pos_reset3", 0, 0, 0, 0, 0, 0);

    // Win on the last round.
    step("win_jogada", 0, 1, 0, 0, 0, 0);
    step("win_registra", 0, 0, 0, 0, 0, 0);
    step("win_comparacao", 0, 0, 1, 1, 1, 0);
    check("acertou", {28'd0, db_estado_a, acertou_a, pronto_a, contaL_a}, 32'h56);
    step("win_hold", 0, 0, 0, 0, 0, 0);

    // Randomized play against the rule model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        async_reset("rnd_reset");
      end else begin
        step("rnd",
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) != 0,
             $urandom_range(0, 1) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
